sprite_commit_sequencer: RTL

Frame-synchronous register commit controller for the two-sprite engine. The CPU writes sprite position and bitmap words into a shadow bank at any time. On request, the sequencer copies only the changed (dirty) words into the engine's active registers during the next vertical blank, one word per cycle. This removes tearing and the "config only when not streaming" restriction. It sits between the TinyQV register decode and the sprite engine's active register file, and raises a per-frame completion interrupt.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_shadow_regfile.sv | 55 +++++
 rtl/sprite_commit_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, word map and FSM state type for the sprite commit sequencer.
package sprite_pkg;

  localparam int NUM_WORDS = 20;
  localparam int AW        = 5;
  localparam int DW        = 16;

  localparam logic [AW-1:0] SPR0_POS  = 5'd0;
  localparam logic [AW-1:0] SPR0_BMP0 = 5'd1;
  localparam logic [AW-1:0] SPR1_POS  = 5'd10;
  localparam logic [AW-1:0] SPR1_BMP0 = 5'd11;
  localparam logic [AW-1:0] LAST_WORD = 5'd19;
  localparam logic [AW-1:0] PTR_ONE   = 5'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a <= LAST_WORD);
  endfunction

endpackage

// File: rtl/sprite_shadow_regfile.sv
// Shadow word bank with per-word dirty bits, CPU write port, readback mux and copy port.
module sprite_shadow_regfile
  import sprite_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          clr_en,
  input  logic [AW-1:0] cp_addr,
  output logic [DW-1:0] cp_data,
  output logic          cp_dirty
);

  logic [DW-1:0]        shadow_q [NUM_WORDS];
  logic [DW-1:0]        shadow_d [NUM_WORDS];
  logic [NUM_WORDS-1:0] dirty_q;
  logic [NUM_WORDS-1:0] dirty_d;

  // Next-state: the CPU write is applied after the copy clear so it wins the dirty bit.
  always_comb begin
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    if (clr_en && addr_valid(cp_addr)) begin
      dirty_d[cp_addr] = 1'b0;
    end else begin
      dirty_d = dirty_d;
    end
    if (wr_en && addr_valid(wr_addr)) begin
      shadow_d[wr_addr] = wr_data;
      dirty_d[wr_addr]  = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{default: 16'h0000};
      dirty_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

  assign rd_data  = addr_valid(rd_addr) ? shadow_q[rd_addr] : 16'h0000;
  assign cp_data  = addr_valid(cp_addr) ? shadow_q[cp_addr] : 16'h0000;
  assign cp_dirty = addr_valid(cp_addr) ? dirty_q[cp_addr]  : 1'b0;

endmodule

// File: rtl/sprite_commit_sequencer.sv
// Frame-synchronous commit controller: copies dirty shadow words to the active
// registers during vertical blank, one word per cycle, with completion irq.
module sprite_commit_sequencer
  import sprite_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          commit_req,
  input  logic          irq_clr,
  input  logic          vblank,
  output logic          act_we,
  output logic [AW-1:0] act_addr,
  output logic [DW-1:0] act_data,
  output logic          busy,
  output logic          irq,
  output logic          overrun
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          vblank_q;
  logic          irq_q, irq_d;
  logic          ovr_q, ovr_d;
  logic          irq_set, ovr_set, clr_en;
  logic          vb_rise, in_copy;
  logic [DW-1:0] cp_data;
  logic          cp_dirty;

  sprite_shadow_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .clr_en   (clr_en),
    .cp_addr  (ptr_q),
    .cp_data  (cp_data),
    .cp_dirty (cp_dirty)
  );

  assign vb_rise = vblank & ~vblank_q;
  assign in_copy = (state_q == COPY);

  // COPY watches the registered vblank so every act_* output stays flop-driven.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    irq_set = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
        else            state_d = IDLE;
      end
      ARMED: begin
        if (vb_rise) begin
          state_d = COPY;
          ptr_d   = '0;
        end else begin
          state_d = ARMED;
        end
      end
      COPY: begin
        if (vblank_q) begin
          clr_en = 1'b1;
          if (ptr_q == LAST_WORD) begin
            state_d = DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end else begin
          ovr_set = 1'b1;
          state_d = ARMED;
          ptr_d   = '0;
        end
      end
      DONE: begin
        irq_set = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // A set in the same cycle as irq_clr takes priority.
  always_comb begin
    irq_d = irq_set | (irq_q & ~irq_clr);
    ovr_d = ovr_set | (ovr_q & ~irq_clr);
  end

  // Control and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      vblank_q <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      vblank_q <= vblank;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  assign act_we   = in_copy & vblank_q & cp_dirty;
  assign act_addr = in_copy ? ptr_q : 5'd0;
  assign act_data = in_copy ? cp_data : 16'h0000;
  assign busy     = (state_q != IDLE);
  assign irq      = irq_q;
  assign overrun  = ovr_q;

endmodule
